uart_rx_cmd: RTL and testbench

- UART 8N1 receiver on the board `rx` pin, directly upstream of the top-level `cmd` register and LED logic.
- Deserialises bytes and presents each one on a single-entry valid/ready holding register.
- Flags framing and overrun errors.
- Runs in the fabric clock domain (ring-oscillator or PLL), so bit timing is a parameter.

---
 rtl/uart_rx_cmd_pkg.sv | 21 ++
 rtl/uart_bit_timer.sv | 31 +++
 rtl/uart_rx_cmd.sv | 181 ++++++++++++++++++
 tb/tb_uart_rx_cmd.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_cmd_pkg.sv
// Shared UART definitions: FSM state encodings and default bit timing.
// The future uart_tx on `tx` imports the same package.
package uart_rx_cmd_pkg;

  localparam int UART_CLKS_PER_BIT_DEF = 16;
  localparam int UART_DATA_BITS        = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4,
    ST_PARITY    = 3'd5
  } uart_state_e;

  function automatic int half_bit(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts clk cycles and ticks at the half-bit or full-bit
// sample point, wrapping to zero on every tick.
module uart_bit_timer
  import uart_rx_cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic half_sel,
  output logic sample_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(half_bit(CLKS_PER_BIT) - 1);

  logic [CW-1:0] cnt;

  assign sample_tick = !clear && (cnt == (half_sel ? HALF_LAST : FULL_LAST));

  always_ff @(posedge clk) begin
    if (rst || clear || sample_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_cmd.sv
// UART 8N1 receiver feeding a single-entry valid/ready holding register.
// Define UART_RX_CMD_PARITY_EN for an even-parity bit and the parity_err output.
module uart_rx_cmd
  import uart_rx_cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
`ifdef UART_RX_CMD_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  logic [SYNC_STAGES-1:0]    sync_p0;
  logic                      rxs;
  uart_state_e               state, state_next;
  logic [2:0]                bit_cnt;
  logic [UART_DATA_BITS-1:0] shift;
  logic                      tick;
  logic                      timer_clear;
  logic                      half_sel;
  logic                      shift_en;
  logic                      deliver_set;
  logic                      frame_set;
  logic                      deliver_p1;
`ifdef UART_RX_CMD_PARITY_EN
  logic                      par_en;
  logic                      par_bit;
  logic                      parity_bad;
  logic                      parity_set;
`endif

  assign rxs  = sync_p0[SYNC_STAGES-1];
  assign busy = (state != ST_IDLE);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clear      (timer_clear),
    .half_sel   (half_sel),
    .sample_tick(tick)
  );

`ifdef UART_RX_CMD_PARITY_EN
  // Even parity: data bits plus parity bit must hold an even number of ones.
  assign parity_bad = (^shift) ^ par_bit;
`endif

  always_comb begin
    state_next  = state;
    timer_clear = 1'b0;
    half_sel    = 1'b0;
    shift_en    = 1'b0;
    deliver_set = 1'b0;
    frame_set   = 1'b0;
`ifdef UART_RX_CMD_PARITY_EN
    par_en      = 1'b0;
    parity_set  = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        timer_clear = 1'b1;
        if (!rxs) state_next = ST_START;
      end
      ST_START: begin
        half_sel = 1'b1;
        if (tick) state_next = rxs ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_RX_CMD_PARITY_EN
            state_next = ST_PARITY;
`else
            state_next = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_CMD_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          par_en     = 1'b1;
          state_next = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // Returning to IDLE mid-stop-bit lets a back-to-back start bit be caught.
        if (tick) begin
          if (rxs) begin
            state_next = ST_IDLE;
`ifdef UART_RX_CMD_PARITY_EN
            if (parity_bad) parity_set = 1'b1;
            else            deliver_set = 1'b1;
`else
            deliver_set = 1'b1;
`endif
          end else begin
            frame_set  = 1'b1;
            state_next = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: begin
        timer_clear = 1'b1;
        if (rxs) state_next = ST_IDLE;
      end
      default: begin
        timer_clear = 1'b1;
        state_next  = ST_IDLE;
      end
    endcase
  end

  // Stage p0: input synchroniser and frame FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '1;
      state   <= ST_IDLE;
      bit_cnt <= 3'd0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], rx};
      state   <= state_next;
      if (state == ST_IDLE)  bit_cnt <= 3'd0;
      else if (shift_en)     bit_cnt <= bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (shift_en) shift <= {rxs, shift[UART_DATA_BITS-1:1]};
`ifdef UART_RX_CMD_PARITY_EN
    if (par_en)   par_bit <= rxs;
`endif
  end

  // Stage p1: delivery into the holding register, one cycle after the stop sample
  always_ff @(posedge clk) begin
    if (rst) begin
      deliver_p1 <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      valid      <= 1'b0;
      data       <= 8'h00;
`ifdef UART_RX_CMD_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      deliver_p1 <= deliver_set;
      frame_err  <= frame_set;
`ifdef UART_RX_CMD_PARITY_EN
      parity_err <= parity_set;
`endif
      overrun    <= 1'b0;
      if (deliver_p1) begin
        if (!valid || ready) begin
          data  <= shift;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cmd.sv
// Directed bench for uart_rx_cmd at CLKS_PER_BIT=16, SYNC_STAGES=2.
// Parity steps compile in only when UART_RX_CMD_PARITY_EN is defined.
module tb_uart_rx_cmd;

  localparam int CPB = 16;
  localparam int LAT = 155;  // 2 sync + 8 half-bit + 9*16 + 1

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_CMD_PARITY_EN
  logic       parity_err;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  int         cyc = 0;
  int         vrise_cyc = 0;
  logic [7:0] last_data = 8'h00;
  logic       valid_q = 1'b0;
  int         n_vrise = 0;
  int         n_frame = 0;
  int         n_over = 0;
  int         n_busy = 0;
  int         n_perr = 0;

  uart_rx_cmd #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
`ifdef UART_RX_CMD_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid && !valid_q) begin
      vrise_cyc <= cyc;
      last_data <= data;
      n_vrise   <= n_vrise + 1;
    end
    valid_q <= valid;
    n_frame <= n_frame + int'(frame_err);
    n_over  <= n_over + int'(overrun);
    n_busy  <= n_busy + int'(busy);
`ifdef UART_RX_CMD_PARITY_EN
    n_perr  <= n_perr + int'(parity_err);
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // par < 0 sends no parity bit; abort_bit >= 0 pulses rst mid-way through that bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int par,
                            input int abort_bit);
    int   nbits;
    logic v;
    nbits = (par < 0) ? 10 : 11;
    for (int i = 0; i < nbits; i++) begin
      if (i == 0)                    v = 1'b0;
      else if (i <= 8)               v = b[i-1];
      else if (i == 9 && par >= 0)   v = par[0];
      else                           v = stop_bit;
      rx = v;
      for (int c = 0; c < CPB; c++) begin
        if (i == abort_bit && c == 8) begin
          rst = 1'b1;
          step();
          rst = 1'b0;
          rx  = 1'b1;
          return;
        end
        step();
      end
    end
  endtask

  int t0, b_vr, b_fr, b_ov, b_bs, b_pe;

  initial begin
    // Reset state
    wait_cycles(4);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_data", 32'(data), 32'h0);
    rst = 1'b0;

    // Clean 0xA5 with ready high
    ready = 1'b1;
    wait_cycles(50);
    b_vr = n_vrise; b_fr = n_frame; b_ov = n_over;
    t0 = cyc;
    send_frame(8'hA5, 1'b1, -1, -1);
    wait_cycles(10);
    chk("a5_latency", 32'(vrise_cyc - t0), 32'(1 + LAT));
    chk("a5_data", 32'(last_data), 32'hA5);
    chk("a5_valid_rises", 32'(n_vrise - b_vr), 32'd1);
    chk("a5_valid_dropped", 32'(valid), 32'h0);
    chk("a5_frame_err", 32'(n_frame - b_fr), 32'd0);
    chk("a5_overrun", 32'(n_over - b_ov), 32'd0);

    // Start-bit glitch of 5 cycles
    b_vr = n_vrise; b_fr = n_frame; b_ov = n_over; b_bs = n_busy;
    rx = 1'b0;
    wait_cycles(5);
    rx = 1'b1;
    wait_cycles(6);
    chk("glitch_busy_end", 32'(busy), 32'h0);
    chk("glitch_busy_cycles", 32'(n_busy - b_bs), 32'd8);
    wait_cycles(10);
    chk("glitch_valid", 32'(n_vrise - b_vr), 32'd0);
    chk("glitch_frame_err", 32'(n_frame - b_fr), 32'd0);
    chk("glitch_overrun", 32'(n_over - b_ov), 32'd0);

    // 0x3C with a low stop bit, line then held low (break)
    b_vr = n_vrise; b_fr = n_frame;
    send_frame(8'h3C, 1'b0, -1, -1);
    wait_cycles(40);
    chk("break_busy_held", 32'(busy), 32'h1);
    rx = 1'b1;
    wait_cycles(5);
    chk("break_busy_released", 32'(busy), 32'h0);
    chk("break_frame_err", 32'(n_frame - b_fr), 32'd1);
    chk("break_valid", 32'(n_vrise - b_vr), 32'd0);

    // Back-to-back 0x11, 0x22 with ready low
    ready = 1'b0;
    wait_cycles(20);
    b_vr = n_vrise; b_ov = n_over;
    send_frame(8'h11, 1'b1, -1, -1);
    send_frame(8'h22, 1'b1, -1, -1);
    wait_cycles(5);
    chk("ovr_valid", 32'(valid), 32'h1);
    chk("ovr_data", 32'(data), 32'h11);
    chk("ovr_overrun", 32'(n_over - b_ov), 32'd1);
    chk("ovr_valid_rises", 32'(n_vrise - b_vr), 32'd1);
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("ovr_consumed", 32'(valid), 32'h0);
    chk("ovr_data_hold", 32'(data), 32'h11);

    // Reset during data bit 4 of 0x5A, then 0x81
    ready = 1'b1;
    wait_cycles(20);
    b_vr = n_vrise;
    send_frame(8'h5A, 1'b1, -1, 5);
    wait_cycles(30);
    chk("abort_no_valid", 32'(n_vrise - b_vr), 32'd0);
    chk("abort_busy", 32'(busy), 32'h0);
    t0 = cyc;
    send_frame(8'h81, 1'b1, -1, -1);
    wait_cycles(10);
    chk("post_rst_latency", 32'(vrise_cyc - t0), 32'(1 + LAT));
    chk("post_rst_data", 32'(last_data), 32'h81);
    chk("post_rst_rises", 32'(n_vrise - b_vr), 32'd1);

`ifdef UART_RX_CMD_PARITY_EN
    // 0x07 with wrong then correct even-parity bit
    wait_cycles(20);
    b_vr = n_vrise; b_pe = n_perr;
    send_frame(8'h07, 1'b1, 0, -1);
    wait_cycles(10);
    chk("par_bad_err", 32'(n_perr - b_pe), 32'd1);
    chk("par_bad_valid", 32'(n_vrise - b_vr), 32'd0);
    t0 = cyc;
    send_frame(8'h07, 1'b1, 1, -1);
    wait_cycles(10);
    chk("par_ok_data", 32'(last_data), 32'h07);
    chk("par_ok_rises", 32'(n_vrise - b_vr), 32'd1);
    chk("par_ok_latency", 32'(vrise_cyc - t0), 32'(1 + LAT + CPB));
    chk("par_ok_err", 32'(n_perr - b_pe), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
